rr_arb_n_pipe: RTL and testbench
================================

Name: rr_arb_n_pipe

Overview:
N-way round-robin arbiter with a registered output stage and a valid/ready handshake toward the consumer.
It generalises the fixed 4-way tree arbiter into a flat, parametrised search from a rotating priority pointer.
It adds back-pressure (the grant is held while stalled) and a per-requester lock mode that allows bounded back-to-back bursts.
It sits between N request sources and a single shared resource port.

Parameters:
N, 8, number of requesters (N >= 1).
MAX_BURST, 4, maximum consecutive grants to one locked requester (>= 1).
PTR_W, max(1, clog2(N)), derived width of pointer and grant index; not overridable.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
req  input  N  per-requester request level.
lock  input  N  per-requester burst request; sampled only for the current winner.
gnt_valid  output  1  registered grant valid.
gnt_ready  input  1  consumer accepts the grant this cycle when high with gnt_valid.
grant_r  output  N  registered one-hot winner; all-zero when gnt_valid=0.
grant_id  output  PTR_W  registered binary index of the winner; 0 when gnt_valid=0.

Behaviour:
- Reset (rst_n=0 at clk edge): gnt_valid=0, grant_r=0, grant_id=0, ptr=0, burst_cnt=0. Reset overrides everything, including a stall in progress.
- Arbitration (combinational):
  - Search req starting at index ptr, ascending, wrapping from N-1 to 0.
  - The first set bit is the winner.
  - no_req = (req==0).
- Stage-free condition: load_en = !gnt_valid || gnt_ready.
- When load_en is high:
  - If !no_req: gnt_valid<=1, grant_r<=onehot(winner), grant_id<=winner.
  - If no_req: gnt_valid<=0, grant_r<=0, grant_id<=0.
- Stall (gnt_valid && !gnt_ready):
  - grant_r, grant_id, gnt_valid, ptr and burst_cnt all hold.
  - Changes on req or lock are ignored until the stage frees.
  - A requester dropping req while stalled does not revoke its grant.
- Pointer and burst update, only on a load with !no_req:
  - Locked continuation: if lock[winner]=1 and burst_cnt < MAX_BURST-1, then ptr<=winner and burst_cnt<=burst_cnt+1.
  - Otherwise: ptr<=(winner+1) mod N and burst_cnt<=0.
  - MAX_BURST=1 therefore disables locking entirely.
- A locked requester that drops req loses priority naturally. The next winner differs from ptr, and burst_cnt then counts from that new winner.
- If the previous winner differs from the current winner, burst_cnt is treated as 0 before the lock compare (track last_id internally).
- A load with no_req leaves ptr and burst_cnt unchanged.
- Latency: req asserted in cycle t appears on grant_r after the edge ending cycle t, provided load_en is high in cycle t.
- Throughput: one grant per cycle while gnt_ready=1.
- N=1: ptr stays 0; the single requester is granted every cycle it requests.
- Invariants: grant_r is always zero or one-hot; grant_id == index of grant_r whenever gnt_valid=1; mod-N wrap is exact for non-power-of-2 N.

Test Plan:
- Reset and rotation (N=4): hold rst_n=0 for 2 edges with req=4'hF, gnt_ready=1.
  - Outputs must be 0 throughout reset.
  - After release, grant_r must be 0001, 0010, 0100, 1000, 0001 on successive cycles; grant_id 0,1,2,3,0.
- Skip and wrap (N=4): req=4'b1001 constant, gnt_ready=1 -> grant_r 0001, 1000, 0001, 1000.
- Back-pressure (N=4): req=4'hF, gnt_ready=0 for 3 cycles after the first grant.
  - grant_r must stay 0001 with gnt_valid=1 throughout the stall.
  - Then set gnt_ready=1 -> next grant 0010.
  - Drop req[0] mid-stall -> grant_r must remain 0001.
- Lock burst (N=4, MAX_BURST=2): req=4'b0011, lock=4'b0001, gnt_ready=1 -> grant_r 0001, 0001, 0010, 0001, 0001, 0010.
- Idle and mid-stall reset (N=4):
  - After one accepted grant, set req=0 -> gnt_valid=0 and grant_r=0 on the next cycle.
  - Separately, assert rst_n=0 while stalled with gnt_valid=1 -> next edge gnt_valid=0, and the following grant starts from index 0.
- Non-power-of-2 (N=5): req=5'b10001, gnt_ready=1 -> grant_id 0, 4, 0, 4, with no index above 4.

Source files
------------

// File: rtl/rr_arb_n_pipe.sv
// N-way round-robin arbiter with a registered grant stage, valid/ready back-pressure
// and bounded back-to-back bursts for requesters that assert lock.
module rr_arb_n_pipe #(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned PTR_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [N-1:0]     grant_r,
    output logic [PTR_W-1:0] grant_id
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic             r_valid;
    logic [N-1:0]     r_grant;
    logic [PTR_W-1:0] r_id;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_last;

    logic [PTR_W:0]   w_idx;
    logic [PTR_W-1:0] w_winner;
    logic [PTR_W-1:0] w_next_ptr;
    logic [N-1:0]     w_onehot;
    logic [CNT_W-1:0] w_eff_cnt;
    logic             w_no_req;
    logic             w_load_en;
    logic             w_lock_cont;

    // Walk from the farthest offset back to ptr so the nearest requester wins last.
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + (PTR_W + 1)'(i);
            if (w_idx >= (PTR_W + 1)'(N)) begin
                w_idx = w_idx - (PTR_W + 1)'(N);
            end
            if (req[w_idx[PTR_W-1:0]]) begin
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_onehot           = '0;
        w_onehot[w_winner] = 1'b1;
    end

    assign w_no_req    = ~|req;
    assign w_load_en   = !r_valid || gnt_ready;
    assign w_next_ptr  = (w_winner == PTR_W'(N - 1)) ? '0 : w_winner + 1'b1;
    // A change of winner starts a fresh burst regardless of the stored count.
    assign w_eff_cnt   = (w_winner == r_last) ? r_cnt : '0;
    assign w_lock_cont = lock[w_winner] && (w_eff_cnt < CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_grant <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
        end else if (w_load_en) begin
            if (w_no_req) begin
                r_valid <= 1'b0;
                r_grant <= '0;
                r_id    <= '0;
            end else begin
                r_valid <= 1'b1;
                r_grant <= w_onehot;
                r_id    <= w_winner;
                r_last  <= w_winner;
                if (w_lock_cont) begin
                    r_ptr <= w_winner;
                    r_cnt <= w_eff_cnt + 1'b1;
                end else begin
                    r_ptr <= w_next_ptr;
                    r_cnt <= '0;
                end
            end
        end
    end

    assign gnt_valid = r_valid;
    assign grant_r   = r_grant;
    assign grant_id  = r_id;

endmodule

// File: tb/tb_rr_arb_n_pipe.sv
// Bench for rr_arb_n_pipe: directed vector table on N=4, hand sequence on N=5,
// then randomized traffic on both checked against a behavioural model.
module tb_rr_arb_n_pipe;

    logic       clk;
    logic       rst_n;
    logic [3:0] req4, lock4;
    logic       rdy4;
    logic       v4;
    logic [3:0] g4;
    logic [1:0] id4;
    logic [4:0] req5, lock5;
    logic       rdy5;
    logic       v5;
    logic [4:0] g5;
    logic [2:0] id5;

    int vectors = 0;
    int miscompares = 0;

    rr_arb_n_pipe #(.N(4), .MAX_BURST(2)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req4),
        .lock      (lock4),
        .gnt_valid (v4),
        .gnt_ready (rdy4),
        .grant_r   (g4),
        .grant_id  (id4)
    );

    rr_arb_n_pipe #(.N(5), .MAX_BURST(3)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req5),
        .lock      (lock5),
        .gnt_valid (v5),
        .gnt_ready (rdy5),
        .grant_r   (g5),
        .grant_id  (id5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state kept as plain integers, winner found by modular search.
    typedef struct {
        bit v;
        int id;
        int ptr;
        int cnt;
        int last;
    } mst_t;

    mst_t m4 = '{v: 0, id: 0, ptr: 0, cnt: 0, last: 0};
    mst_t m5 = '{v: 0, id: 0, ptr: 0, cnt: 0, last: 0};

    function automatic mst_t model_step(mst_t s, int n, int mb, bit rstn,
                                        logic [7:0] rq, logic [7:0] lk, bit rdy);
        mst_t t = s;
        int   w = 0;
        int   eff;
        bit   found = 0;
        if (!rstn) begin
            t = '{v: 0, id: 0, ptr: 0, cnt: 0, last: 0};
            return t;
        end
        if (s.v && !rdy) return t;
        for (int k = 0; k < n; k++) begin
            if (!found && rq[(s.ptr + k) % n]) begin
                found = 1;
                w     = (s.ptr + k) % n;
            end
        end
        if (!found) begin
            t.v  = 0;
            t.id = 0;
            return t;
        end
        t.v  = 1;
        t.id = w;
        eff  = (w == s.last) ? s.cnt : 0;
        if (lk[w] && eff < mb - 1) begin
            t.ptr = w;
            t.cnt = eff + 1;
        end else begin
            t.ptr = (w + 1) % n;
            t.cnt = 0;
        end
        t.last = w;
        return t;
    endfunction

    always @(posedge clk) begin
        m4 <= model_step(m4, 4, 2, rst_n, {4'b0, req4}, {4'b0, lock4}, rdy4);
        m5 <= model_step(m5, 5, 3, rst_n, {3'b0, req5}, {3'b0, lock5}, rdy5);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         rstn;
        logic [3:0] req;
        logic [3:0] lock;
        bit         rdy;
        bit         ev;
        logic [3:0] eg;
        logic [1:0] eid;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int exp_ids[4];
        int ids_tmp[4] = '{0, 4, 0, 4};
        exp_ids = ids_tmp;

        // reset + rotation
        tbl.push_back(vec_t'{0, 4'hF, 4'h0, 1, 0, 4'b0000, 2'd0});
        tbl.push_back(vec_t'{0, 4'hF, 4'h0, 1, 0, 4'b0000, 2'd0});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 1, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 1, 1, 4'b0010, 2'd1});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 1, 1, 4'b0100, 2'd2});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 1, 1, 4'b1000, 2'd3});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 1, 1, 4'b0001, 2'd0});
        // skip and wrap
        tbl.push_back(vec_t'{0, 4'h9, 4'h0, 1, 0, 4'b0000, 2'd0});
        tbl.push_back(vec_t'{1, 4'h9, 4'h0, 1, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'h9, 4'h0, 1, 1, 4'b1000, 2'd3});
        tbl.push_back(vec_t'{1, 4'h9, 4'h0, 1, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'h9, 4'h0, 1, 1, 4'b1000, 2'd3});
        // back-pressure, req[0] dropped mid-stall
        tbl.push_back(vec_t'{0, 4'hF, 4'h0, 1, 0, 4'b0000, 2'd0});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 0, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 0, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'hE, 4'h0, 0, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 0, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 1, 1, 4'b0010, 2'd1});
        // lock burst, MAX_BURST=2
        tbl.push_back(vec_t'{0, 4'h3, 4'h1, 1, 0, 4'b0000, 2'd0});
        tbl.push_back(vec_t'{1, 4'h3, 4'h1, 1, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'h3, 4'h1, 1, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'h3, 4'h1, 1, 1, 4'b0010, 2'd1});
        tbl.push_back(vec_t'{1, 4'h3, 4'h1, 1, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'h3, 4'h1, 1, 1, 4'b0001, 2'd0});
        tbl.push_back(vec_t'{1, 4'h3, 4'h1, 1, 1, 4'b0010, 2'd1});
        // idle, then reset in the middle of a stall
        tbl.push_back(vec_t'{1, 4'h0, 4'h0, 1, 0, 4'b0000, 2'd0});
        tbl.push_back(vec_t'{1, 4'h4, 4'h0, 1, 1, 4'b0100, 2'd2});
        tbl.push_back(vec_t'{1, 4'h4, 4'h0, 0, 1, 4'b0100, 2'd2});
        tbl.push_back(vec_t'{0, 4'hF, 4'h0, 0, 0, 4'b0000, 2'd0});
        tbl.push_back(vec_t'{1, 4'hF, 4'h0, 1, 1, 4'b0001, 2'd0});

        rst_n = 1'b0;
        req4  = '0;
        lock4 = '0;
        rdy4  = 1'b1;
        req5  = '0;
        lock5 = '0;
        rdy5  = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rstn;
            req4  = tbl[i].req;
            lock4 = tbl[i].lock;
            rdy4  = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d valid", i), 32'(v4), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d grant", i), 32'(g4), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d id", i), 32'(id4), 32'(tbl[i].eid));
        end

        // N=5 skip and wrap across the non-power-of-2 boundary
        rst_n = 1'b0;
        req5  = 5'b10001;
        lock5 = '0;
        rdy5  = 1'b1;
        @(posedge clk);
        #1;
        chk("n5 reset valid", 32'(v5), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n5 seq%0d valid", k), 32'(v5), 32'd1);
            chk($sformatf("n5 seq%0d id", k), 32'(id5), 32'(exp_ids[k]));
            chk($sformatf("n5 seq%0d grant", k), 32'(g5), 32'(1) << exp_ids[k]);
            chk($sformatf("n5 seq%0d id range", k), 32'(id5 <= 3'd4), 32'd1);
        end

        // randomized traffic on both instances against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            req4  = 4'($urandom) & 4'($urandom);
            lock4 = 4'($urandom);
            rdy4  = ($urandom_range(0, 3) != 0);
            req5  = 5'($urandom) & 5'($urandom | $urandom);
            lock5 = 5'($urandom);
            rdy5  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            chk("rnd4 valid", 32'(v4), 32'(m4.v));
            chk("rnd4 grant", 32'(g4), m4.v ? (32'(1) << m4.id) : 32'd0);
            chk("rnd4 id", 32'(id4), 32'(m4.id));
            chk("rnd5 valid", 32'(v5), 32'(m5.v));
            chk("rnd5 grant", 32'(g5), m5.v ? (32'(1) << m5.id) : 32'd0);
            chk("rnd5 id", 32'(id5), 32'(m5.id));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
